pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush controller for the five-stage pipeline. It drives the PC enable, the F/D register enable, the D/E bubble insert and the pipeline-wide exception flush. It combines register-dependency (Tuse/Tnew) stalls, a multiply/divide busy sequencer, and exception-request priority. It sits beside the D stage, taking decoded hazard info from D, E and M and feeding the enables of the PC and the F/D and D/E registers.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start (1..15)
- DIV_CYC, 10, busy cycles after a div/divu start (1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- D_rs_addr, D_rt_addr  in  5  source registers of the instruction in D
- D_rs_tuse, D_rt_tuse  in  2  cycles until the operand is needed; 3 means unused
- E_A3, M_A3  in  5  destination register of the instruction in E / M; 0 means none
- E_Tnew, M_Tnew  in  2  cycles until the E / M result is available
- D_md_use  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- E_md_start  in  1  mult/div issuing in E this cycle
- E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
- Req  in  1  exception/interrupt taken this cycle
- PC_EN  out  1  PC update enable
- F_D_REG_EN  out  1  F/D register enable
- D_E_REG_CLR  out  1  load a NOP bubble into D/E
- Flush  out  1  pipeline-wide flush, routed to every Req input
- md_busy  out  1  multiply/divide unit busy
- md_cnt  out  4  remaining busy cycles

## Operation
Dependency stall (combinational):
- rs_stall = D_rs_addr≠0 and either:
  - E_A3==D_rs_addr and D_rs_tuse<E_Tnew, or
  - M_A3==D_rs_addr and D_rs_tuse<M_Tnew.
- rt_stall is the same with the rt inputs.
- Comparisons are 2-bit unsigned. Tuse=3 never stalls.

MD sequencer FSM, states IDLE and BUSY, 4-bit down-counter md_cnt:
- IDLE: on E_md_start and not Req, load md_cnt with DIV_CYC if E_md_div=1, else MULT_CYC, and go to BUSY.
- BUSY: decrement every cycle. When md_cnt reaches 1 and is decremented, go to IDLE (md_cnt=0).
- E_md_start while in BUSY reloads the counter and stays in BUSY. Decode should prevent this case, but the behaviour is defined.
- md_busy = E_md_start or state==BUSY.
- md_stall = D_md_use and md_busy.

Output rules:
- stall = rs_stall or rt_stall or md_stall.
- Req=1 overrides everything:
  - Flush=1, PC_EN=1 (PC loads the handler), F_D_REG_EN=1, D_E_REG_CLR=0.
  - Stall is ignored.
  - E_md_start in the same cycle is ignored, because that instruction is younger than the faulting one.
  - An operation already counting continues to completion.
- Req=0, stall=1: PC_EN=0, F_D_REG_EN=0, D_E_REG_CLR=1, Flush=0.
- Req=0, stall=0: PC_EN=1, F_D_REG_EN=1, D_E_REG_CLR=0, Flush=0.

## Timing
- Stall, flush and enable outputs are combinational from inputs and current state; zero-cycle latency within the cycle.
- MD start in cycle t: md_busy=1 in cycle t, and in cycles t+1 .. t+N with N = MULT_CYC/DIV_CYC. md_cnt=N at t+1 and 0 at t+N+1.
- A D-stage HI/LO user in cycle t+N+1 proceeds without stall.
- Reset asserted (reset=0): state=IDLE and md_cnt=0 immediately. Outputs while in reset follow the output rules with the current inputs. Asserting reset mid-count aborts the count.
- Deassertion is synchronised externally; the first edge after deassertion may load a start.

## Configuration
- PIPE_HAZARD_STALL_CNT_EN defined:
  - adds output stall_cnt (out, 32), a saturating counter of cycles with Req=0 and stall=1.
  - stall_cnt is cleared by reset.
  - it holds at 32'hFFFF_FFFF once reached.
- PIPE_HAZARD_STALL_CNT_EN not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Load-use: D_rs_addr=5, D_rs_tuse=0, E_A3=5, E_Tnew=2 -> PC_EN=0, F_D_REG_EN=0, D_E_REG_CLR=1. Next cycle M_A3=5, M_Tnew=1 -> stall again. Then M_Tnew=0 -> stall released.
- Register zero: D_rs_addr=0, E_A3=0, E_Tnew=2, Tuse=0 -> no stall.
- Mult: E_md_start=1, E_md_div=0 at t -> md_cnt=5 at t+1, 0 at t+6. D_md_use held from t -> stalled t..t+5, released at t+6.
- Div with reset: div start at t, then reset=0 at t+4 -> md_cnt=0 and md_busy=0 at once. A D_md_use instruction is not stalled after reset release.
- Req priority: stall condition active, E_md_start=1, Req=1 -> Flush=1, PC_EN=1, D_E_REG_CLR=0, state stays IDLE, md_cnt=0 next cycle.
- Req during BUSY: Req=1 while md_cnt=3 -> counting continues 2, 1, 0.
- With PIPE_HAZARD_STALL_CNT_EN: 7 stall cycles -> stall_cnt=7.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller with Tuse/Tnew dependency stalls, mult/div busy sequencer and exception priority.
// Optional cycle counter of stalled cycles enabled by PIPE_HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  logic [1:0] E_Tnew,
  input  logic [1:0] M_Tnew,
  input  logic       D_md_use,
  input  logic       E_md_start,
  input  logic       E_md_div,
  input  logic       Req,
  output logic       PC_EN,
  output logic       F_D_REG_EN,
  output logic       D_E_REG_CLR,
  output logic       Flush,
  output logic       md_busy,
  output logic [3:0] md_cnt
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt_nxt;
  logic rs_stall, rt_stall, md_stall, stall, start;
  assign rs_stall = (D_rs_addr != 5'd0) &&
                    ((E_A3 == D_rs_addr && D_rs_tuse < E_Tnew) || (M_A3 == D_rs_addr && D_rs_tuse < M_Tnew));
  assign rt_stall = (D_rt_addr != 5'd0) &&
                    ((E_A3 == D_rt_addr && D_rt_tuse < E_Tnew) || (M_A3 == D_rt_addr && D_rt_tuse < M_Tnew));
  assign md_busy = E_md_start || state == BUSY;
  assign md_stall = D_md_use && md_busy;
  assign stall = rs_stall || rt_stall || md_stall;
  // a start alongside Req belongs to a younger, squashed instruction
  assign start = E_md_start && !Req;
  assign Flush = Req;
  assign PC_EN = Req || !stall;
  assign F_D_REG_EN = Req || !stall;
  assign D_E_REG_CLR = !Req && stall;
  always_comb begin
    state_nxt = state;
    cnt_nxt = md_cnt;
    if (start) begin
      state_nxt = BUSY;
      cnt_nxt = E_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    end else if (state == BUSY) begin
      cnt_nxt = md_cnt - 4'd1;
      state_nxt = md_cnt == 4'd1 ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      md_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      md_cnt <= cnt_nxt;
    end
  end
`ifdef PIPE_HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= 32'd0;
    else if (D_E_REG_CLR && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a remaining-cycles reference model, scoreboard-checked.
module tb_pipe_hazard_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  typedef struct {
    logic [4:0] rs, rt, ea3, ma3;
    logic [1:0] rsu, rtu, etn, mtn;
    logic mduse, ms, mdiv, req, rst_n;
  } stim_t;
  typedef struct {
    logic [8:0] o;
    longint sc;
    int id;
  } exp_t;
  logic clk = 0, reset = 0;
  logic [4:0] D_rs_addr, D_rt_addr, E_A3, M_A3;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_Tnew, M_Tnew;
  logic D_md_use, E_md_start, E_md_div, Req;
  logic PC_EN, F_D_REG_EN, D_E_REG_CLR, Flush, md_busy;
  logic [3:0] md_cnt;
`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  exp_t q[$];
  int checks = 0, errors = 0, nstep = 0;
  int rem = 0;
  longint sc = 0;
  pipe_hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .D_md_use(D_md_use), .E_md_start(E_md_start), .E_md_div(E_md_div), .Req(Req),
    .PC_EN(PC_EN), .F_D_REG_EN(F_D_REG_EN), .D_E_REG_CLR(D_E_REG_CLR), .Flush(Flush),
    .md_busy(md_busy), .md_cnt(md_cnt)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic bit dep(input logic [4:0] a, input logic [1:0] u, input stim_t s);
    return a != 0 && ((s.ea3 == a && int'(u) < int'(s.etn)) || (s.ma3 == a && int'(u) < int'(s.mtn)));
  endfunction
  task automatic step(input stim_t s);
    exp_t e;
    bit busy, stl;
    @(negedge clk);
    D_rs_addr = s.rs; D_rt_addr = s.rt; D_rs_tuse = s.rsu; D_rt_tuse = s.rtu;
    E_A3 = s.ea3; M_A3 = s.ma3; E_Tnew = s.etn; M_Tnew = s.mtn;
    D_md_use = s.mduse; E_md_start = s.ms; E_md_div = s.mdiv; Req = s.req; reset = s.rst_n;
    if (!s.rst_n) begin rem = 0; sc = 0; end
    #2;
    busy = s.ms || rem > 0;
    stl = dep(s.rs, s.rsu, s) || dep(s.rt, s.rtu, s) || (s.mduse && busy);
    e.o = s.req ? {4'b1101, busy, 4'(rem)} : stl ? {4'b0010, busy, 4'(rem)} : {4'b1100, busy, 4'(rem)};
    e.sc = sc;
    e.id = nstep++;
    q.push_back(e);
    if (s.rst_n) begin
      if (s.ms && !s.req) rem = s.mdiv ? DC : MC;
      else if (rem > 0) rem--;
      if (!s.req && stl && sc < 64'hFFFF_FFFF) sc++;
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({PC_EN, F_D_REG_EN, D_E_REG_CLR, Flush, md_busy, md_cnt} !== e.o) begin
          errors++;
          $display("FAIL outs step %0d: got %b want %b", e.id,
                   {PC_EN, F_D_REG_EN, D_E_REG_CLR, Flush, md_busy, md_cnt}, e.o);
        end
`ifdef PIPE_HAZARD_STALL_CNT_EN
        checks++;
        if (longint'(stall_cnt) != e.sc) begin
          errors++;
          $display("FAIL stall_cnt step %0d: got %0d want %0d", e.id, stall_cnt, e.sc);
        end
`endif
      end
    end
  end
  initial begin
    stim_t z, s;
    z = '{rs: 0, rt: 0, ea3: 0, ma3: 0, rsu: 3, rtu: 3, etn: 0, mtn: 0,
          mduse: 0, ms: 0, mdiv: 0, req: 0, rst_n: 1};
    s = z; s.rst_n = 0;
    step(s); step(s);
    step(z);
    s = z; s.rs = 5; s.rsu = 0; s.ea3 = 5; s.etn = 2; step(s);
    s.ea3 = 0; s.ma3 = 5; s.mtn = 1; step(s);
    s.mtn = 0; step(s);
    s = z; s.rsu = 0; s.etn = 2; step(s);
    s = z; s.ms = 1; s.mduse = 1; step(s);
    s.ms = 0;
    for (int i = 0; i < 7; i++) step(s);
    s = z; s.ms = 1; s.mdiv = 1; step(s);
    s.ms = 0;
    for (int i = 0; i < 3; i++) step(s);
    s.rst_n = 0; s.mduse = 1; step(s);
    s.rst_n = 1; step(s);
    s = z; s.rs = 5; s.rsu = 0; s.ea3 = 5; s.etn = 2; s.ms = 1; s.req = 1; step(s);
    step(z);
    s = z; s.ms = 1; step(s);
    step(z); step(z);
    s = z; s.req = 1; step(s);
    for (int i = 0; i < 4; i++) step(z);
    s = z; s.rt = 7; s.rtu = 1; s.ma3 = 7; s.mtn = 2;
    for (int i = 0; i < 7; i++) step(s);
    for (int i = 0; i < 3000; i++) begin
      s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
      s.ea3 = 5'($urandom_range(0, 3)); s.ma3 = 5'($urandom_range(0, 3));
      s.rsu = 2'($urandom); s.rtu = 2'($urandom); s.etn = 2'($urandom); s.mtn = 2'($urandom);
      s.mduse = $urandom_range(0, 3) == 0; s.ms = $urandom_range(0, 7) == 0;
      s.mdiv = 1'($urandom); s.req = $urandom_range(0, 15) == 0;
      s.rst_n = $urandom_range(0, 59) != 0;
      step(s);
    end
    step(z);
    #20;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
